kernel_control_host: RTL and testbench

KERNEL_CONTROL_HOST -- requirements
Module: kernel_control_host

---
 rtl/kernel_control_host.sv | 134 +++++++++++++
 tb/tb_kernel_control_host.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_control_host.sv
// Host-side launcher for an ap_ctrl_chain kernel: runs a commanded number of
// invocations back to back, with a per-phase watchdog that parks the block in ERROR.
module kernel_control_host #(
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CNT_W          = 32
) (
  input  logic             ap_clk,
  input  logic             areset,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_iterations,
  output logic             cmd_ready,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] iter_count,
  output logic             timeout_err
);

  localparam int unsigned     WD_W    = 32;
  localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_CONTINUE  = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             wd_expired;

  // Kernel idle is informational only; nothing in the sequencing depends on it.
  logic unused_ap_idle;
  assign unused_ap_idle = ap_idle;

  assign wd_expired = WD_EN && (wd_q == WD_LAST);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      iter_q      <= '0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      iter_q      <= iter_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    iter_d      = iter_q;
    wd_d        = wd_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          remaining_d = cmd_iterations;
          iter_d      = '0;
          wd_d        = '0;
          state_d     = (cmd_iterations == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wd_d = wd_q + WD_W'(1);
        // ap_done only counts once the start has been taken.
        if (ap_ready) begin
          wd_d    = '0;
          state_d = ap_done ? S_CONTINUE : S_WAIT_DONE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WD_W'(1);
        if (ap_done) begin
          state_d = S_CONTINUE;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = S_ERROR;
        end
      end
      S_CONTINUE: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (iter_q != '1) iter_d = iter_q + CNT_W'(1);
        if (remaining_q > CNT_W'(1)) begin
          wd_d    = '0;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    busy        = 1'b0;
    done_pulse  = 1'b0;
    case (state_q)
      S_IDLE:      cmd_ready = 1'b1;
      S_LAUNCH:    begin ap_start = 1'b1; busy = 1'b1; end
      S_WAIT_DONE: busy = 1'b1;
      S_CONTINUE:  begin ap_continue = 1'b1; busy = 1'b1; end
      S_FINISH:    begin done_pulse = 1'b1; busy = 1'b1; end
      default:     ;
    endcase
    iter_count  = iter_q;
    timeout_err = timeout_q;
  end

endmodule

// File: tb/tb_kernel_control_host.sv
// Bench for kernel_control_host: kernel model, event scoreboard for continue/done,
// and cycle-exact checks on the launch, timeout and reset corner cases.
module tb_kernel_control_host;

  localparam int RDY_DLY  = 2;
  localparam int DONE_DLY = 5;

  typedef struct packed {
    logic        is_done;
    logic [31:0] iters;
  } exp_t;

  logic        ap_clk, areset, cmd_valid;
  logic [31:0] cmd_iterations;
  logic        cmd_ready, ap_start, ap_continue, busy, done_pulse, timeout_err;
  logic        ap_ready, ap_done, ap_idle;
  logic [31:0] iter_count;

  logic        cmd_ready0, ap_start0, ap_continue0, busy0, done_pulse0, timeout_err0;
  logic [31:0] iter_count0;
  logic        tie0;

  int   n_checks, n_errs;
  exp_t exp_q[$];
  int   k_mode, k_phase, k_cnt;

  kernel_control_host #(.TIMEOUT_CYCLES(8)) dut (
    .ap_clk(ap_clk), .areset(areset), .cmd_valid(cmd_valid), .cmd_iterations(cmd_iterations),
    .cmd_ready(cmd_ready), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle), .busy(busy),
    .done_pulse(done_pulse), .iter_count(iter_count), .timeout_err(timeout_err)
  );

  // Watchdog disabled: kernel never answers, so this one must wait forever without error.
  kernel_control_host #(.TIMEOUT_CYCLES(0)) dut0 (
    .ap_clk(ap_clk), .areset(areset), .cmd_valid(cmd_valid), .cmd_iterations(cmd_iterations),
    .cmd_ready(cmd_ready0), .ap_start(ap_start0), .ap_continue(ap_continue0),
    .ap_ready(tie0), .ap_done(tie0), .ap_idle(tie0), .busy(busy0),
    .done_pulse(done_pulse0), .iter_count(iter_count0), .timeout_err(timeout_err0)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic d, input logic [31:0] n);
    exp_t e;
    e.is_done = d;
    e.iters   = n;
    return e;
  endfunction

  task automatic push_cmd(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk_exp(1'b0, 32'(i)));
    exp_q.push_back(mk_exp(1'b1, 32'(n)));
  endtask

  // Kernel model: mode 0 normal, 1 ready+done at once, 2 hung, 3 done before ready.
  initial begin
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1; tie0 = 1'b0;
    k_phase = 0; k_cnt = 0;
    forever begin
      @(negedge ap_clk);
      if (busy !== 1'b1) begin
        ap_ready = 1'b0; ap_done = 1'b0; k_phase = 0; k_cnt = 0;
      end else if (k_mode == 1) begin
        ap_ready = ap_start;
        ap_done  = ap_start | ap_continue;
      end else if (k_mode == 2) begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
      end else if (k_mode == 3) begin
        if (ap_start) k_cnt++;
        ap_ready = ap_start && (k_cnt >= 3);
        ap_done  = ap_start | ap_continue;
      end else begin
        case (k_phase)
          0: if (ap_start) begin k_phase = 1; k_cnt = 1; end
          1: if (k_cnt >= RDY_DLY - 1) begin ap_ready = 1'b1; k_phase = 2; k_cnt = 0; end
             else k_cnt++;
          2: begin
            ap_ready = 1'b0;
            k_cnt++;
            if (k_cnt >= DONE_DLY) begin ap_done = 1'b1; k_phase = 3; end
          end
          3: if (ap_continue) begin ap_done = 1'b0; k_phase = 0; end
          default: k_phase = 0;
        endcase
      end
      ap_idle = (k_phase == 0) && !ap_done;
    end
  end

  // Scoreboard: every continue/done pulse must match the next expected event.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_continue === 1'b1 || done_pulse === 1'b1) begin
      check_eq("sb_event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_kind", 32'(done_pulse), 32'(e.is_done));
        check_eq("sb_iter_count", iter_count, e.iters);
      end
    end
  end

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic issue(input int n);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 100) begin
      @(negedge ap_clk);
      k++;
    end
    check_eq("issue_ready", 32'(cmd_ready === 1'b1), 32'd1);
    push_cmd(n);
    cmd_iterations = 32'(n);
    cmd_valid      = 1'b1;
    @(negedge ap_clk);
    cmd_valid      = 1'b0;
  endtask

  task automatic wait_idle(output int n_cont, output int n_done);
    bit ok;
    ok = 1'b0; n_cont = 0; n_done = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge ap_clk);
      if (ap_continue === 1'b1) n_cont++;
      if (done_pulse === 1'b1)  n_done++;
      if (cmd_ready === 1'b1)   ok = 1'b1;
    end
    check_eq("wait_idle_in_budget", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    cmd_valid = 1'b0;
    @(negedge ap_clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_ap_start", 32'(ap_start), 32'd0);
    check_eq("rst_ap_continue", 32'(ap_continue), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done_pulse", 32'(done_pulse), 32'd0);
    check_eq("rst_iter_count", iter_count, 32'd0);
    check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
    areset = 1'b0;
  endtask

  initial begin
    int  nc, nd, cont_seen, ready_hits;
    bit  found, prev_done;
    n_checks = 0; n_errs = 0; k_mode = 0;
    areset = 1'b1; cmd_valid = 1'b0; cmd_iterations = '0;
    do_reset();

    // Three iterations through the normal kernel model.
    issue(3);
    check_eq("s3_start_t1", 32'(ap_start), 32'd1);
    check_eq("s3_busy_t1", 32'(busy), 32'd1);
    check_eq("s3_ready_t1", 32'(cmd_ready), 32'd0);
    wait_idle(nc, nd);
    check_eq("s3_continues", 32'(nc), 32'd3);
    check_eq("s3_done_pulses", 32'(nd), 32'd1);
    check_eq("s3_iter_count", iter_count, 32'd3);

    // Zero iterations: straight to FINISH.
    issue(0);
    check_eq("z_no_start", 32'(ap_start), 32'd0);
    check_eq("z_done_t1", 32'(done_pulse), 32'd1);
    check_eq("z_iter_t1", iter_count, 32'd0);
    @(negedge ap_clk);
    check_eq("z_ready_t2", 32'(cmd_ready), 32'd1);
    check_eq("z_busy_t2", 32'(busy), 32'd0);

    // Ready and done together in the first LAUNCH cycle.
    k_mode = 1;
    issue(1);
    check_eq("f_start_t1", 32'(ap_start), 32'd1);
    @(negedge ap_clk);
    check_eq("f_continue_t2", 32'(ap_continue), 32'd1);
    check_eq("f_start_t2", 32'(ap_start), 32'd0);
    @(negedge ap_clk);
    check_eq("f_done_t3", 32'(done_pulse), 32'd1);
    check_eq("f_iter_t3", iter_count, 32'd1);
    @(negedge ap_clk);
    check_eq("f_ready_t4", 32'(cmd_ready), 32'd1);

    // ap_done high before ap_ready must not end LAUNCH.
    k_mode = 3;
    issue(1);
    @(negedge ap_clk);
    check_eq("e_start_t2", 32'(ap_start), 32'd1);
    check_eq("e_cont_t2", 32'(ap_continue), 32'd0);
    @(negedge ap_clk);
    check_eq("e_cont_t3", 32'(ap_continue), 32'd0);
    @(negedge ap_clk);
    check_eq("e_cont_t4", 32'(ap_continue), 32'd1);
    wait_idle(nc, nd);
    check_eq("e_iter_count", iter_count, 32'd1);

    // Hung kernel: watchdog fires after 8 LAUNCH cycles.
    k_mode = 2;
    issue(2);
    repeat (7) @(negedge ap_clk);
    check_eq("t_start_t8", 32'(ap_start), 32'd1);
    check_eq("t_err_t8", 32'(timeout_err), 32'd0);
    @(negedge ap_clk);
    check_eq("t_err_t9", 32'(timeout_err), 32'd1);
    check_eq("t_start_t9", 32'(ap_start), 32'd0);
    check_eq("t_busy_t9", 32'(busy), 32'd0);
    check_eq("t_ready_t9", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    repeat (10) @(negedge ap_clk);
    check_eq("t_err_sticky", 32'(timeout_err), 32'd1);
    check_eq("t_ready_held", 32'(cmd_ready), 32'd0);
    check_eq("t_cont_held", 32'(ap_continue), 32'd0);
    exp_q.delete();
    k_mode = 0;
    do_reset();

    // Reset in WAIT_DONE of iteration 2 of 4.
    issue(4);
    cont_seen = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge ap_clk);
      if (ap_continue === 1'b1) cont_seen++;
      else if (cont_seen == 1 && busy === 1'b1 && ap_start === 1'b0) found = 1'b1;
    end
    check_eq("r_reached_wait2", 32'(found), 32'd1);
    check_eq("r_iter_before", iter_count, 32'd1);
    exp_q.delete();
    do_reset();
    nc = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (ap_continue === 1'b1) nc++;
      if (done_pulse === 1'b1) nd++;
    end
    check_eq("r_no_continue", 32'(nc), 32'd0);
    check_eq("r_no_done", 32'(nd), 32'd0);
    issue(1);
    check_eq("r_restart_start", 32'(ap_start), 32'd1);
    wait_idle(nc, nd);
    check_eq("r_restart_iter", iter_count, 32'd1);

    // cmd_valid held through a 2-iteration command.
    push_cmd(2);
    cmd_iterations = 32'd2;
    cmd_valid      = 1'b1;
    @(negedge ap_clk);
    check_eq("h_start_t1", 32'(ap_start), 32'd1);
    cmd_iterations = 32'd1;
    found = 1'b0; prev_done = 1'b0; ready_hits = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge ap_clk);
      if (cmd_ready === 1'b1) found = 1'b1;
      else prev_done = (done_pulse === 1'b1);
    end
    check_eq("h_idle_reached", 32'(found), 32'd1);
    check_eq("h_idle_after_done", 32'(prev_done), 32'd1);
    push_cmd(1);
    @(negedge ap_clk);
    cmd_valid = 1'b0;
    check_eq("h_second_accepted", 32'(busy), 32'd1);
    check_eq("h_second_start", 32'(ap_start), 32'd1);
    if (cmd_ready === 1'b1) ready_hits++;
    check_eq("h_ready_low", 32'(ready_hits), 32'd0);
    wait_idle(nc, nd);
    check_eq("h_second_iter", iter_count, 32'd1);

    repeat (5) @(negedge ap_clk);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("nowd_no_err", 32'(timeout_err0), 32'd0);
    check_eq("nowd_still_launch", 32'(ap_start0), 32'd1);
    check_eq("nowd_busy", 32'(busy0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
